// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor: bit-serial A-B, LSB first, start/busy/done handshake.
// Optional SERIAL_ADDSUB_EN adds an op port (0 = subtract, 1 = add).
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADDSUB_EN
  input  logic             op,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] ra, rb, res;
  logic [CW-1:0]    cnt;
  logic             br, sa, sb;
  logic             bit_d, br_next, accept, last;
  logic [WIDTH-1:0] res_next;
  logic             ovf_next;
`ifdef SERIAL_ADDSUB_EN
  logic             op_r;
`endif

  assign accept   = start && (state != SHIFT);
  assign last     = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
  assign busy     = (state == SHIFT);
  assign done     = (state == DONE);
  assign bit_d    = ra[0] ^ rb[0] ^ br;
  assign res_next = {bit_d, res[WIDTH-1:1]};

  always_comb begin
    br_next  = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
    ovf_next = (sa != sb) && (bit_d != sa);
`ifdef SERIAL_ADDSUB_EN
    if (op_r) begin
      br_next  = (ra[0] & rb[0]) | (br & (ra[0] ^ rb[0]));
      ovf_next = (sa == sb) && (bit_d != sa);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (last)  next_state = DONE;
      DONE:    next_state = start ? SHIFT : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra       <= '0;
      rb       <= '0;
      res      <= '0;
      cnt      <= '0;
      br       <= 1'b0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
`ifdef SERIAL_ADDSUB_EN
      op_r     <= 1'b0;
`endif
    end else begin
      if (accept) begin
        ra   <= a;
        rb   <= b;
        sa   <= a[WIDTH-1];
        sb   <= b[WIDTH-1];
        br   <= 1'b0;
        cnt  <= '0;
`ifdef SERIAL_ADDSUB_EN
        op_r <= op;
`endif
      end else if (state == SHIFT) begin
        ra  <= ra >> 1;
        rb  <= rb >> 1;
        res <= res_next;
        br  <= br_next;
        cnt <= cnt + 1'b1;
      end
      // Results are published only on the edge that completes the last shift.
      if (last) begin
        diff     <= res_next;
        borrow   <= br_next;
        overflow <= ovf_next;
        zero     <= (res_next == '0);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
`default_nettype none

module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = 8'h00, b = 8'h00;
  logic       busy, done, borrow, overflow, zero;
  logic [7:0] diff;
`ifdef SERIAL_ADDSUB_EN
  logic       op = 1'b0;
`endif

  int compared = 0;
  int mismatched = 0;
  logic [7:0] cur_diff = 8'h00;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef SERIAL_ADDSUB_EN
    .op(op),
`endif
    .a(a), .b(b), .busy(busy), .done(done), .diff(diff),
    .borrow(borrow), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full operation; optionally fires a second start mid-operation.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [7:0] ed, input logic eb, input logic eo,
                        input logic ez, input logic inject);
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk1("busy_during", busy, 1'b1);
      chk1("done_during", done, 1'b0);
      chk8("diff_stable", diff, cur_diff);
      if (inject && i == 2) begin a = 8'hFF; b = 8'h00; start = 1'b1; end
      if (inject && i == 3) start = 1'b0;
      @(negedge clk);
    end
    chk1("done_pulse", done, 1'b1);
    chk1("busy_at_done", busy, 1'b0);
    chk8("diff", diff, ed);
    chk1("borrow", borrow, eb);
    chk1("overflow", overflow, eo);
    chk1("zero", zero, ez);
    cur_diff = ed;
    @(negedge clk);
    chk1("done_drop", done, 1'b0);
    chk1("idle_busy", busy, 1'b0);
  endtask

  initial begin
    #2;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk8("rst_diff", diff, 8'h00);
    chk1("rst_zero", zero, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h35, 8'h12, 8'h23, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(8'h12, 8'h35, 8'hDD, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op(8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op(8'h12, 8'h35, 8'hDD, 1'b1, 1'b0, 1'b0, 1'b0);

    // Abort: reset three edges into an operation clears everything at once.
    @(negedge clk);
    a = 8'h44; b = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
    chk8("abort_diff", diff, 8'h00);
    chk1("abort_borrow", borrow, 1'b0);
    chk1("abort_overflow", overflow, 1'b0);
    chk1("abort_zero", zero, 1'b0);
    cur_diff = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(8'h33, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SERIAL_ADDSUB_EN
    op = 1'b1;
    run_op(8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
    op = 1'b0;
    run_op(8'h7F, 8'h01, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor computing A − B, one bit per clock, LSB first.
- Each step uses a single full-subtractor cell (difference/borrow) with a registered borrow.
- Multi-cycle datapath unit in the arithmetic lab sequence; the counterpart to the combinational full-adder cell.
- Start/busy/done handshake; registered results held until the next operation.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when not busy.
- a  input  WIDTH  minuend, latched on accepted start.
- b  input  WIDTH  subtrahend, latched on accepted start.
- busy  output  1  high while shifting.
- done  output  1  one-cycle pulse when results are valid.
- diff  output  WIDTH  A − B modulo 2^WIDTH.
- borrow  output  1  final borrow-out (unsigned A < B).
- overflow  output  1  signed overflow of A − B.
- zero  output  1  diff == 0.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - rst_n low clears immediately: state=IDLE; busy, done, diff, borrow, overflow, zero = 0.
  - Shift registers, borrow flop and bit counter also clear.
  - Reset mid-operation aborts the operation with no partial result.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge latches a→ra, b→rb, a[WIDTH-1]/b[WIDTH-1] sign bits, borrow flop=0, count=0.
  - Next state SHIFT.
  - Outputs keep previous results.
- SHIFT (busy=1):
  - Each edge: d = ra[0]^rb[0]^br; br ← (~ra[0]&rb[0]) | (~(ra[0]^rb[0])&br).
  - ra, rb shift right; d shifts into the result register MSB.
  - count increments.
  - At the edge completing shift WIDTH: diff, borrow=br_next, overflow=(sa≠sb)&(diff_msb≠sa), zero=(diff==0) register together; go to DONE.
- DONE:
  - done=1, busy=0 for exactly one cycle.
  - Behaves as IDLE for start, so a new start is accepted in this cycle.
  - Otherwise returns to IDLE.
- Latency: done is high in the cycle after WIDTH+1 edges counted from (and including) the edge that sampled start. busy is high for exactly WIDTH cycles.
- Outputs diff/borrow/overflow/zero change only on that completion edge or on reset. They are stable while busy and after done.
- start while busy=1 is ignored; a/b changes during busy have no effect.
- start held high continuously gives back-to-back operations, one every WIDTH+1 cycles.
- Arithmetic is purely modulo 2^WIDTH. borrow is the unsigned comparison result, overflow the signed one; both are computed from the latched operands.

Optional Feature:
- Macro: SERIAL_ADDSUB_EN.
- Defined:
  - Adds input port op (1 bit), latched with the operands.
  - op=0: subtract as above.
  - op=1: add, using the carry form br ← (ra0&rb0)|(br&(ra0^rb0)) and d = ra0^rb0^br.
  - borrow reports carry-out.
  - overflow = (sa==sb)&(diff_msb≠sa).
- Undefined: no op port; subtract only.

Test Plan:
- a=0x35, b=0x12, start pulse:
  - busy for 8 cycles, then done 1 cycle.
  - diff=0x23, borrow=0, overflow=0, zero=0.
- a=0x12, b=0x35 → diff=0xDD, borrow=1, overflow=0, zero=0.
- a=0x80, b=0x01 → diff=0x7F, borrow=0, overflow=1. Then a=0x7F, b=0xFF → diff=0x80, borrow=1, overflow=1.
- a=0x5A, b=0x5A → diff=0x00, zero=1, borrow=0.
- Abort and ignored start:
  - rst_n low for one cycle, 3 edges into an operation → all outputs 0 immediately.
  - Afterwards a=0x10, b=0x01 → diff=0x0F after normal latency.
  - start asserted while busy with different operands is ignored; the result matches the first operands.
- SERIAL_ADDSUB_EN defined, op=1, a=0x7F, b=0x01 → diff=0x80, borrow(carry)=0, overflow=1. Then op=0 on the same operands → diff=0x7E.
